// File: rtl/nand_lab_pkg.sv
// Shared types for the NAND truth-table engine.
// Holds the function-select enum, FSM state enum and width limit.
package nand_lab_pkg;

  localparam int N_IN_MAX = 6;

  typedef enum logic [2:0] {
    MODE_NAND = 3'b000,
    MODE_AND  = 3'b001,
    MODE_OR   = 3'b010,
    MODE_NOR  = 3'b011,
    MODE_XOR  = 3'b100,
    MODE_XNOR = 3'b101,
    MODE_BUF0 = 3'b110,
    MODE_NOT0 = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/nand_func_unit.sv
// Combinational N-input function unit built only from 2-input NANDs.
// Ports: vec (inputs), mode (function select), f (function output).
module nand_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic o
);
  logic w_ns;
  logic w_pa;
  logic w_pb;

  // o = s ? b : a
  nand u_ns (w_ns, s, s);
  nand u_pa (w_pa, a, w_ns);
  nand u_pb (w_pb, b, s);
  nand u_o  (o, w_pa, w_pb);
endmodule

module nand_func_unit
  import nand_lab_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] vec,
  input  mode_t           mode,
  output logic            f
);

  // Each stage folds one more input bit into running AND, NOR and XOR.
  for (genvar i = 0; i < N_IN; i++) begin : g_st
    logic w_inv;
    logic w_and;
    logic w_nor;
    logic w_xor;

    nand u_inv (w_inv, vec[i], vec[i]);

    if (i == 0) begin : g_first
      assign w_and = vec[0];
      assign w_nor = w_inv;
      assign w_xor = vec[0];
    end else begin : g_chain
      logic w_n;
      logic w_o;
      logic w_t;
      logic w_u;
      logic w_v;

      nand u_n  (w_n, g_st[i-1].w_and, vec[i]);
      nand u_a  (w_and, w_n, w_n);

      // ~(~or_prev & ~bit) = or_prev | bit
      nand u_o  (w_o, g_st[i-1].w_nor, w_inv);
      nand u_no (w_nor, w_o, w_o);

      nand u_t  (w_t, g_st[i-1].w_xor, vec[i]);
      nand u_u  (w_u, g_st[i-1].w_xor, w_t);
      nand u_v  (w_v, vec[i], w_t);
      nand u_x  (w_xor, w_u, w_v);
    end
  end

  logic w_f_nand;
  logic w_f_and;
  logic w_f_or;
  logic w_f_nor;
  logic w_f_xor;
  logic w_f_xnor;
  logic w_f_buf;
  logic w_f_not;

  assign w_f_and = g_st[N_IN-1].w_and;
  assign w_f_nor = g_st[N_IN-1].w_nor;
  assign w_f_xor = g_st[N_IN-1].w_xor;
  assign w_f_not = g_st[0].w_inv;

  nand u_fnand (w_f_nand, w_f_and, w_f_and);
  nand u_for   (w_f_or, w_f_nor, w_f_nor);
  nand u_fxnor (w_f_xnor, w_f_xor, w_f_xor);
  nand u_fbuf  (w_f_buf, w_f_not, w_f_not);

  logic [2:0] w_sel;
  logic       w_l1_0;
  logic       w_l1_1;
  logic       w_l1_2;
  logic       w_l1_3;
  logic       w_l2_0;
  logic       w_l2_1;

  assign w_sel = mode;

  nand_mux2 u_m10 (
    .a(w_f_nand), .b(w_f_and), .s(w_sel[0]), .o(w_l1_0));
  nand_mux2 u_m11 (
    .a(w_f_or), .b(w_f_nor), .s(w_sel[0]), .o(w_l1_1));
  nand_mux2 u_m12 (
    .a(w_f_xor), .b(w_f_xnor), .s(w_sel[0]), .o(w_l1_2));
  nand_mux2 u_m13 (
    .a(w_f_buf), .b(w_f_not), .s(w_sel[0]), .o(w_l1_3));
  nand_mux2 u_m20 (
    .a(w_l1_0), .b(w_l1_1), .s(w_sel[1]), .o(w_l2_0));
  nand_mux2 u_m21 (
    .a(w_l1_2), .b(w_l1_3), .s(w_sel[1]), .o(w_l2_1));
  nand_mux2 u_m3 (
    .a(w_l2_0), .b(w_l2_1), .s(w_sel[2]), .o(f));

endmodule

// File: rtl/nand_truth_table_engine.sv
// Sweeps all 2^N_IN input vectors and builds the function's truth table.
// Ports: clk, rst_n, start, mode in; in_vec, y, valid, busy, done, table_out.
module nand_truth_table_engine
  import nand_lab_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int TBL_W = 2 ** N_IN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N_IN-1:0]  in_vec,
  output logic             y,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] table_out
);

  localparam logic [N_IN-1:0] LAST = '1;

  state_t          r_state;
  mode_t           r_mode;
  mode_t           w_eval_mode;
  logic [N_IN-1:0] w_next_vec;
  logic            w_f;

  // Evaluate the vector being loaded on this edge, so y is registered
  // together with in_vec; in IDLE that is vector 0 under the incoming mode.
  assign w_eval_mode = (r_state == ST_IDLE) ? mode_t'(mode) : r_mode;
  assign w_next_vec  = (r_state == ST_IDLE) ? '0 : in_vec + 1'b1;

  nand_func_unit #(
    .N_IN(N_IN)
  ) u_func (
    .vec (w_next_vec),
    .mode(w_eval_mode),
    .f   (w_f)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_NAND;
      in_vec    <= '0;
      y         <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_mode    <= mode_t'(mode);
            in_vec    <= '0;
            y         <= w_f;
            valid     <= 1'b1;
            busy      <= 1'b1;
            table_out <= {{(TBL_W-1){1'b0}}, w_f};
            r_state   <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (in_vec != LAST) begin
            in_vec                <= w_next_vec;
            y                     <= w_f;
            table_out[w_next_vec] <= w_f;
          end else begin
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_truth_table_engine.sv
// Directed bench for nand_truth_table_engine at N_IN = 2, 3 and 6.
// Checks sweep timing, function values, table contents and reset abort.
module tb_nand_truth_table_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       s2 = 1'b0;
  logic [2:0] m2 = 3'b000;
  logic [1:0] v2;
  logic       y2, val2, bsy2, dn2;
  logic [3:0] t2;

  logic       s3 = 1'b0;
  logic [2:0] m3 = 3'b000;
  logic [2:0] v3;
  logic       y3, val3, bsy3, dn3;
  logic [7:0] t3;

  logic        s6 = 1'b0;
  logic [2:0]  m6 = 3'b000;
  logic [5:0]  v6;
  logic        y6, val6, bsy6, dn6;
  logic [63:0] t6;

  nand_truth_table_engine #(.N_IN(2)) d2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .mode(m2),
    .in_vec(v2), .y(y2), .valid(val2), .busy(bsy2),
    .done(dn2), .table_out(t2));

  nand_truth_table_engine #(.N_IN(3)) d3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .mode(m3),
    .in_vec(v3), .y(y3), .valid(val3), .busy(bsy3),
    .done(dn3), .table_out(t3));

  nand_truth_table_engine #(.N_IN(6)) d6 (
    .clk(clk), .rst_n(rst_n), .start(s6), .mode(m6),
    .in_vec(v6), .y(y6), .valid(val6), .busy(bsy6),
    .done(dn6), .table_out(t6));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One N_IN=2 sweep, checked cycle by cycle against exp.
  task automatic run2(input logic [2:0] md,
                      input logic [3:0] exp,
                      input string tag);
    m2 = md;
    s2 = 1'b1;
    tick();
    s2 = 1'b0;
    chk({tag, " tbl@E0"}, 64'(t2), 64'({3'b000, exp[0]}));
    for (int k = 0; k < 4; k++) begin
      chk({tag, " vec"}, 64'(v2), 64'(k));
      chk({tag, " y"}, 64'(y2), 64'(exp[k]));
      chk({tag, " valid"}, 64'(val2), 64'(1));
      chk({tag, " done_lo"}, 64'(dn2), 64'(0));
      chk({tag, " tbl_bit"}, 64'(t2[k]), 64'(exp[k]));
      tick();
    end
    chk({tag, " done"}, 64'(dn2), 64'(1));
    chk({tag, " busy_lo"}, 64'(bsy2), 64'(0));
    chk({tag, " valid_lo"}, 64'(val2), 64'(0));
    chk({tag, " vec_hold"}, 64'(v2), 64'(3));
    chk({tag, " y_hold"}, 64'(y2), 64'(exp[3]));
    chk({tag, " table"}, 64'(t2), 64'(exp));
    tick();
    chk({tag, " done_end"}, 64'(dn2), 64'(0));
  endtask

  // One N_IN=3 sweep; optionally pulses start with a new mode in cycle 3.
  task automatic run3(input logic [2:0] md,
                      input logic [7:0] exp,
                      input bit inject,
                      input string tag);
    int nv;
    int nd;
    int nov;
    int nbad;
    logic [7:0] tdone;
    nv = 0; nd = 0; nov = 0; nbad = 0; tdone = '0;
    m3 = md;
    s3 = 1'b1;
    tick();
    s3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (val3) begin
        nv++;
        if (y3 !== exp[v3] || t3[v3] !== exp[v3]) nbad++;
      end
      if (dn3) begin
        nd++;
        tdone = t3;
      end
      if (dn3 && bsy3) nov++;
      if (inject && i == 2) begin
        m3 = 3'b010;
        s3 = 1'b1;
      end else begin
        s3 = 1'b0;
      end
      tick();
    end
    s3 = 1'b0;
    chk({tag, " valid_cycles"}, 64'(nv), 64'(8));
    chk({tag, " done_pulses"}, 64'(nd), 64'(1));
    chk({tag, " busy_and_done"}, 64'(nov), 64'(0));
    chk({tag, " y_errors"}, 64'(nbad), 64'(0));
    chk({tag, " table"}, 64'(tdone), 64'(exp));
    chk({tag, " table_held"}, 64'(t3), 64'(exp));
  endtask

  initial begin
    int nv6;
    int nd6;
    int nbad6;
    int ndr;
    logic [63:0] tdone6;
    logic [63:0] xnor6;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst vec", 64'(v2), 64'(0));
    chk("rst y", 64'(y2), 64'(0));
    chk("rst valid", 64'(val2), 64'(0));
    chk("rst busy", 64'(bsy2), 64'(0));
    chk("rst done", 64'(dn2), 64'(0));
    chk("rst table2", 64'(t2), 64'(0));
    chk("rst table3", 64'(t3), 64'(0));
    chk("rst table6", t6, 64'(0));
    rst_n = 1'b1;
    tick();

    run2(3'b010, 4'b1110, "or2");
    run2(3'b000, 4'b0111, "nand2");
    run2(3'b011, 4'b0001, "nor2");
    run2(3'b110, 4'b1010, "buf2");
    run2(3'b111, 4'b0101, "not2");

    run3(3'b100, 8'b1001_0110, 1'b0, "xor3");
    run3(3'b001, 8'b1000_0000, 1'b1, "and3_ignore");

    // Reset while in_vec == 2 aborts the sweep.
    m2 = 3'b010;
    s2 = 1'b1;
    tick();
    s2 = 1'b0;
    tick();
    tick();
    chk("abort pre vec", 64'(v2), 64'(2));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort vec", 64'(v2), 64'(0));
    chk("abort y", 64'(y2), 64'(0));
    chk("abort valid", 64'(val2), 64'(0));
    chk("abort busy", 64'(bsy2), 64'(0));
    chk("abort done", 64'(dn2), 64'(0));
    chk("abort table", 64'(t2), 64'(0));
    ndr = 0;
    for (int i = 0; i < 6; i++) begin
      if (dn2 || val2) ndr++;
      tick();
    end
    chk("abort no_done", 64'(ndr), 64'(0));
    run2(3'b001, 4'b1000, "and2_after_rst");

    // N_IN=6 XNOR: complement of the parity pattern.
    xnor6 = 64'h9669_6996_6996_9669;
    nv6 = 0; nd6 = 0; nbad6 = 0; tdone6 = '0;
    m6 = 3'b101;
    s6 = 1'b1;
    tick();
    s6 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (val6) begin
        nv6++;
        if (y6 !== xnor6[v6]) nbad6++;
      end
      if (dn6) begin
        nd6++;
        tdone6 = t6;
      end
      tick();
    end
    chk("xnor6 valid_cycles", 64'(nv6), 64'(64));
    chk("xnor6 done_pulses", 64'(nd6), 64'(1));
    chk("xnor6 y_errors", 64'(nbad6), 64'(0));
    chk("xnor6 table", tdone6, xnor6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
